// File: rtl/cgol_memory_controller_if.sv
// Bus between the cell-logic/control side and the Game of Life board storage.
// The master drives requests and top-FSM state; the slave (storage) returns board data.
interface cgol_memory_controller_if #(
  parameter int GEN_WIDTH = 16
);
  logic [1:0]           i_state_top;
  logic [1:0]           memory_operation;
  logic [5:0]           memory_operation_address;
  logic                 i_data;
  logic                 i_load;
  logic [63:0]          i_load_board;
  logic                 o_data;
  logic [63:0]          o_board;
  logic [6:0]           o_population;
  logic [GEN_WIDTH-1:0] o_generation;
  logic                 o_cycle_done;

  modport master (
    output i_state_top, memory_operation, memory_operation_address,
           i_data, i_load, i_load_board,
    input  o_data, o_board, o_population, o_generation, o_cycle_done
  );

  modport slave (
    input  i_state_top, memory_operation, memory_operation_address,
           i_data, i_load, i_load_board,
    output o_data, o_board, o_population, o_generation, o_cycle_done
  );
endinterface

// File: rtl/cgol_memory_controller.sv
// Double-buffered 8x8 Game of Life board: cell logic reads the current board and
// writes the next one; the next board is promoted once per CYCLE_REGISTERS interval.
module cgol_memory_controller #(
  parameter logic [63:0] INIT_PATTERN = 64'h0000_0000_0000_0000,
  parameter int          GEN_WIDTH    = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  cgol_memory_controller_if.slave bus
);

  typedef enum logic [1:0] {
    TOP_PROCESS_GAME = 2'b00,
    TOP_CYCLE_REGS   = 2'b01,
    TOP_PROCESS_OUT  = 2'b10,
    TOP_PAUSE        = 2'b11
  } top_state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_IDLE  = 2'b10,
    OP_NONE  = 2'b11
  } mem_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [63:0]          rd_board_q, rd_board_d;
  logic [63:0]          wr_board_q, wr_board_d;
  logic                 data_q, data_d;
  logic [6:0]           pop_q, pop_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic                 done_q, done_d;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) s = s + 7'(v[i]);
    return s;
  endfunction

  logic [6:0] wr_pop;
  logic [6:0] load_pop;
  logic       in_game;

  assign wr_pop   = popcount64(wr_board_q);
  assign load_pop = popcount64(bus.i_load_board);
  assign in_game  = (bus.i_state_top == TOP_PROCESS_GAME);

  always_comb begin
    state_d    = state_q;
    rd_board_d = rd_board_q;
    wr_board_d = wr_board_q;
    data_d     = data_q;
    pop_d      = pop_q;
    gen_d      = gen_q;
    done_d     = 1'b0;

    // Cell-logic accesses; writes land in the next board only, so no bypass exists.
    if (in_game) begin
      if (bus.memory_operation == OP_READ)
        data_d = rd_board_q[bus.memory_operation_address];
      else if (bus.memory_operation == OP_WRITE)
        wr_board_d[bus.memory_operation_address] = bus.i_data;
    end

    unique case (state_q)
      ST_RUN: begin
        if (bus.i_state_top == TOP_CYCLE_REGS) begin
          rd_board_d = wr_board_q;
          pop_d      = wr_pop;
          gen_d      = gen_q + 1'b1;
          done_d     = 1'b1;
          state_d    = ST_WAIT;
        end else if (bus.i_state_top == TOP_PAUSE && bus.i_load) begin
          rd_board_d = bus.i_load_board;
          wr_board_d = bus.i_load_board;
          pop_d      = load_pop;
          gen_d      = '0;
        end
      end
      ST_WAIT: begin
        // Holding here makes a long CYCLE_REGISTERS phase promote only once.
        if (bus.i_state_top != TOP_CYCLE_REGS) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      rd_board_q <= INIT_PATTERN;
      wr_board_q <= '0;
      data_q     <= 1'b0;
      pop_q      <= '0;
      gen_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_board_q <= rd_board_d;
      wr_board_q <= wr_board_d;
      data_q     <= data_d;
      pop_q      <= pop_d;
      gen_q      <= gen_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_board      = rd_board_q;
  assign bus.o_population = pop_q;
  assign bus.o_generation = gen_q;
  assign bus.o_cycle_done = done_q;

endmodule

// File: tb/tb_cgol_memory_controller.sv
// Bench for cgol_memory_controller: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a board-level model.
module tb_cgol_memory_controller;

  localparam logic [63:0] INIT = 64'h0000_0000_0000_0007;
  localparam int          GW   = 16;

  localparam logic [1:0] PGS = 2'b00, CYC = 2'b01, POUT = 2'b10, PAUSE = 2'b11;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, IDL = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cgol_memory_controller_if #(.GEN_WIDTH(GW)) bus ();

  cgol_memory_controller #(.INIT_PATTERN(INIT), .GEN_WIDTH(GW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int passCount = 0;
  int totalChecks = 0;
  logic checkEn = 1'b0;

  // Model state: boards as plain vectors, population via $countones.
  logic [63:0]   mRd, mWr;
  logic          mData, mDone, mPromoted;
  logic [6:0]    mPop;
  logic [GW-1:0] mGen;

  always @(posedge clk) begin
    if (!rst_n) begin
      mRd <= INIT; mWr <= '0; mData <= 1'b0; mPop <= '0; mGen <= '0;
      mDone <= 1'b0; mPromoted <= 1'b0;
    end else begin
      mDone <= 1'b0;
      if (bus.i_state_top == PGS) begin
        if (bus.memory_operation == RD) mData <= mRd[bus.memory_operation_address];
        else if (bus.memory_operation == WR) mWr[bus.memory_operation_address] <= bus.i_data;
      end
      if (bus.i_state_top == CYC) begin
        if (!mPromoted) begin
          mRd <= mWr; mPop <= 7'($countones(mWr)); mGen <= mGen + 1'b1;
          mDone <= 1'b1; mPromoted <= 1'b1;
        end
      end else begin
        mPromoted <= 1'b0;
        if (bus.i_state_top == PAUSE && bus.i_load && !mPromoted) begin
          mRd <= bus.i_load_board; mWr <= bus.i_load_board;
          mPop <= 7'($countones(bus.i_load_board)); mGen <= '0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    totalChecks++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model o_data",       64'(bus.o_data),       64'(mData));
      checkOutput("model o_board",      bus.o_board,           mRd);
      checkOutput("model o_population", 64'(bus.o_population), 64'(mPop));
      checkOutput("model o_generation", 64'(bus.o_generation), 64'(mGen));
      checkOutput("model o_cycle_done", 64'(bus.o_cycle_done), 64'(mDone));
    end
  end

  // Drive inputs at a negedge, let one posedge sample them, return at the next negedge.
  task automatic applyStimulus(input logic [1:0] top, input logic [1:0] op, input logic [5:0] addr,
                               input logic din, input logic ld, input logic [63:0] board);
    bus.i_state_top = top;
    bus.memory_operation = op;
    bus.memory_operation_address = addr;
    bus.i_data = din;
    bus.i_load = ld;
    bus.i_load_board = board;
    @(negedge clk);
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0;
    applyStimulus(PGS, IDL, 6'd0, 1'b0, 1'b0, '0);
    checkEn = 1'b1;
    applyStimulus(PGS, IDL, 6'd0, 1'b0, 1'b0, '0);
    checkOutput("reset o_board", bus.o_board, 64'h7);
    checkOutput("reset o_population", 64'(bus.o_population), 64'd0);
    checkOutput("reset o_generation", 64'(bus.o_generation), 64'd0);
    checkOutput("reset o_cycle_done", 64'(bus.o_cycle_done), 64'd0);
    checkOutput("reset o_data", 64'(bus.o_data), 64'd0);
    rst_n = 1'b1;

    applyStimulus(PGS, RD, 6'd1, 1'b0, 1'b0, '0);
    checkOutput("read addr1", 64'(bus.o_data), 64'd1);

    applyStimulus(PGS, WR, 6'h09, 1'b1, 1'b0, '0);
    applyStimulus(PGS, WR, 6'h12, 1'b1, 1'b0, '0);
    applyStimulus(PGS, WR, 6'h3F, 1'b1, 1'b0, '0);
    applyStimulus(PGS, RD, 6'h09, 1'b0, 1'b0, '0);
    checkOutput("no bypass", 64'(bus.o_data), 64'd0);

    pulses = 0;
    applyStimulus(CYC, IDL, 6'd0, 1'b0, 1'b0, '0);
    checkOutput("promote o_board", bus.o_board, 64'h8000_0000_0004_0200);
    checkOutput("promote pop", 64'(bus.o_population), 64'd3);
    checkOutput("promote gen", 64'(bus.o_generation), 64'd1);
    pulses += int'(bus.o_cycle_done);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(CYC, IDL, 6'd0, 1'b0, 1'b0, '0);
      pulses += int'(bus.o_cycle_done);
    end
    checkOutput("one pulse per interval", 64'(pulses), 64'd1);
    checkOutput("held gen", 64'(bus.o_generation), 64'd1);
    applyStimulus(PGS, IDL, 6'd0, 1'b0, 1'b0, '0);
    applyStimulus(CYC, IDL, 6'd0, 1'b0, 1'b0, '0);
    checkOutput("second pulse", 64'(bus.o_cycle_done), 64'd1);
    checkOutput("second gen", 64'(bus.o_generation), 64'd2);

    applyStimulus(PGS, IDL, 6'd0, 1'b0, 1'b0, '0);
    applyStimulus(PAUSE, IDL, 6'd0, 1'b0, 1'b1, {64{1'b1}});
    checkOutput("load board", bus.o_board, {64{1'b1}});
    checkOutput("load pop", 64'(bus.o_population), 64'd64);
    checkOutput("load gen", 64'(bus.o_generation), 64'd0);
    checkOutput("load no pulse", 64'(bus.o_cycle_done), 64'd0);
    applyStimulus(CYC, IDL, 6'd0, 1'b0, 1'b0, '0);
    checkOutput("post-load board", bus.o_board, {64{1'b1}});
    checkOutput("post-load pop", 64'(bus.o_population), 64'd64);
    checkOutput("post-load gen", 64'(bus.o_generation), 64'd1);

    applyStimulus(POUT, IDL, 6'd0, 1'b0, 1'b0, '0);
    applyStimulus(POUT, WR, 6'd0, 1'b0, 1'b0, '0);
    applyStimulus(POUT, RD, 6'd0, 1'b0, 1'b0, '0);
    checkOutput("read ignored outside game", 64'(bus.o_data), 64'd0);
    applyStimulus(PGS, IDL, 6'd0, 1'b0, 1'b1, 64'h0);
    checkOutput("load ignored in game", bus.o_board, {64{1'b1}});
    applyStimulus(CYC, IDL, 6'd0, 1'b0, 1'b0, '0);
    checkOutput("write ignored outside game", bus.o_board, {64{1'b1}});
    checkOutput("gen after write test", 64'(bus.o_generation), 64'd2);

    rst_n = 1'b0;
    applyStimulus(CYC, IDL, 6'd0, 1'b0, 1'b0, '0);
    checkOutput("reset in wait pulse", 64'(bus.o_cycle_done), 64'd0);
    checkOutput("reset in wait board", bus.o_board, 64'h7);
    checkOutput("reset in wait gen", 64'(bus.o_generation), 64'd0);
    rst_n = 1'b1;

    // Random traffic, game-state heavy so boards evolve between promotions.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] top;
      int r;
      r = int'($urandom_range(0, 9));
      top = (r < 5) ? PGS : (r < 7) ? CYC : (r < 8) ? POUT : PAUSE;
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus(top, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                    1'($urandom), ($urandom_range(0, 3) == 0), {$urandom, $urandom});
    end

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
